riscv_insn_decode_stage: RTL
============================

Name: riscv_insn_decode_stage

Overview:
- Parametrised, pipelined RISC-V RV32I/RV64I base decoder stage sitting between fetch and issue.
- Decodes LANES instructions per beat into per-lane type, register fields, sign-extended immediate, operand-use flags and an illegal flag.
- Registered output with valid/ready handshake, full throughput, and a synchronous flush.

Parameters:
- LANES, 2, instructions decoded per beat (1..4).
- XLEN, 32, immediate width (32 or 64).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  drop the held output beat
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_lane_vld  in  LANES  per-lane instruction present
- in_insn  in  LANES*32  instruction words, lane 0 at LSBs
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts beat
- out_lane_vld  out  LANES  registered in_lane_vld
- out_info  out  LANES*$bits(dec_info_t)  decoded info, lane 0 at LSBs

Behaviour:
- Reset: out_valid=0, out_lane_vld=0, out_info=0; in_ready=1 while rst is deasserted. Reset mid-beat drops the beat.
- in_ready = !out_valid || out_ready (combinational). Transfer on in_valid&&in_ready. One-cycle latency: decoded info is visible the cycle after acceptance.
- Output regs load on transfer; out_valid sets on transfer, clears on out_ready without a new transfer. Accept and drain in the same cycle keeps out_valid=1 with the new data.
- out_valid/out_info are stable while out_valid&&!out_ready.
- flush: next cycle out_valid=0. flush has priority over a same-cycle transfer, which is discarded. in_ready is not gated by flush.
- Per lane, opcode=insn[6:0]:
  - 0110111 LUI, 0010111 AUIPC: U.
  - 1101111 JAL: J.
  - 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM, 0001111 MISC-MEM, 1110011 SYSTEM: I.
  - 0100011 STORE: S.
  - 1100011 BRANCH: B.
  - 0110011 OP: R.
  - XLEN=64 adds 0011011 OP-IMM-32 (I) and 0111011 OP-32 (R).
  - Anything else, or insn[1:0]!=2'b11: type ILLEGAL, illegal=1, rd_we=rs1_used=rs2_used=0, imm=0.
- Fields always extracted: rd=insn[11:7], rs1=insn[19:15], rs2=insn[24:20], funct3=insn[14:12], funct7=insn[31:25].
- Immediates are sign-extended from insn[31] to XLEN:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - R: imm=0.
- Operand-use flags:
  - rd_we = (R|I|U|J) && rd!=0.
  - rs1_used = R|I|S|B, except LUI/AUIPC/JAL (not I type anyway) and MISC-MEM.
  - rs2_used = R|S|B.
- Lanes with in_lane_vld=0 are still decoded but carry no meaning. Consumers qualify with out_lane_vld.

Optional Feature:
- Macro RISCV_DECODE_PERF_EN.
- Defined: adds outputs perf_insn_cnt (32b) and perf_illegal_cnt (32b).
  - On each accepted, non-flushed beat they increment by popcount(in_lane_vld) and popcount(in_lane_vld & illegal) respectively.
  - Both wrap at 2^32 and reset to 0.
- Undefined: counters and ports are absent; behaviour is otherwise identical.

Decomposition:
- Package riscv_decode_pkg holds:
  - enum insn_type_e {R,I,S,B,U,J,ILLEGAL} (3b).
  - Opcode localparams.
  - Packed struct dec_info_t {type, opcode, rd, rs1, rs2, funct3, funct7, imm[63:0] (upper bits zero when XLEN=32), rd_we, rs1_used, rs2_used, illegal}.
- Sub-module riscv_insn_decode_lane: purely combinational single-instruction decoder, instantiated LANES times by generate.
- The stage module owns the handshake, registers and counters.

Test Plan:
- add x3,x1,x2 (0x002081B3) on lane0, in_valid=1 -> next cycle out_valid=1; R, rd=3, rs1=1, rs2=2, rd_we=1, rs2_used=1, imm=0.
- Lane0 addi x1,x0,-1 (0xFFF00093), lane1 sw x2,8(x1) (0x0020A423) -> lane0 I imm=0xFFFFFFFF; lane1 S imm=8, rd_we=0, rs2_used=1.
- beq x0,x0,-4 (0xFE000EE3), lui x5,0x12345 (0x123452B7) -> B imm=0xFFFFFFFC; U imm=0x12345000, rd=5.
- 0x00000000 and 0x0000007F -> illegal=1, type ILLEGAL, all use flags 0; with PERF_EN, perf_illegal_cnt += 2.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_info stable; out_ready=1 -> new beat loads the same cycle, no loss or duplication over 10 back-to-back beats.
- Raise flush with a same-cycle transfer -> out_valid=0 next cycle. Assert rst mid-stream -> out_valid drops immediately, in_ready=1 after release.

Source files
------------

// File: rtl/riscv_decode_pkg.sv
// Shared types for the RV32I/RV64I decode stage: instruction format enum,
// base opcode constants and the per-lane decoded-info record.
package riscv_decode_pkg;

  // Instruction format; ILLEGAL covers every unrecognised encoding.
  typedef enum logic [2:0] {
    R       = 3'd0,
    I       = 3'd1,
    S       = 3'd2,
    B       = 3'd3,
    U       = 3'd4,
    J       = 3'd5,
    ILLEGAL = 3'd6
  } insn_type_e;

  // Base opcodes (insn[6:0]).
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  // Decoded view of one instruction. imm is always 64 bits wide; with
  // XLEN=32 the upper half is zero rather than a sign copy.
  typedef struct packed {
    insn_type_e  itype;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm;
    logic        rd_we;
    logic        rs1_used;
    logic        rs2_used;
    logic        illegal;
  } dec_info_t;

  // Widen a 32-bit sign-extended immediate to the 64-bit record field.
  function automatic logic [63:0] widen_imm(input logic [31:0] imm32, input int xlen);
    if (xlen == 64) return {{32{imm32[31]}}, imm32};
    else            return {32'b0, imm32};
  endfunction

endpackage

// File: rtl/riscv_insn_decode_lane.sv
// Single-instruction RV32I/RV64I base decoder. Purely combinational; the
// stage instantiates one per lane.
module riscv_insn_decode_lane
  import riscv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0] insn,
  output dec_info_t   info
);

  logic [6:0]  opc;
  insn_type_e  itype;
  logic [31:0] imm32;

  assign opc = insn[6:0];

  // Classify the encoding into a format; anything unknown is ILLEGAL.
  always_comb begin
    itype = ILLEGAL;
    if (insn[1:0] == 2'b11) begin
      case (opc)
        OPC_LUI, OPC_AUIPC:                                     itype = U;
        OPC_JAL:                                                itype = J;
        OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: itype = I;
        OPC_STORE:                                              itype = S;
        OPC_BRANCH:                                             itype = B;
        OPC_OP:                                                 itype = R;
        OPC_OP_IMM_32: if (XLEN == 64) itype = I;
        OPC_OP_32:     if (XLEN == 64) itype = R;
        default:                                                itype = ILLEGAL;
      endcase
    end
  end

  // Reassemble the immediate for the format, sign-extended from insn[31].
  always_comb begin
    imm32 = 32'b0;
    case (itype)
      I:       imm32 = {{20{insn[31]}}, insn[31:20]};
      S:       imm32 = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      B:       imm32 = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      U:       imm32 = {insn[31:12], 12'b0};
      J:       imm32 = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      default: imm32 = 32'b0;
    endcase
  end

  // Fields are extracted unconditionally; use flags depend on the format.
  always_comb begin
    info          = '0;
    info.itype    = itype;
    info.opcode   = opc;
    info.rd       = insn[11:7];
    info.rs1      = insn[19:15];
    info.rs2      = insn[24:20];
    info.funct3   = insn[14:12];
    info.funct7   = insn[31:25];
    info.imm      = widen_imm(imm32, XLEN);
    info.illegal  = (itype == ILLEGAL);
    info.rd_we    = (itype == R || itype == I || itype == U || itype == J) &&
                    (insn[11:7] != 5'd0);
    // FENCE is I-format but its rs1 field is not a real source operand.
    info.rs1_used = (itype == R || itype == I || itype == S || itype == B) &&
                    (opc != OPC_MISC_MEM);
    info.rs2_used = (itype == R || itype == S || itype == B);
  end

endmodule

// File: rtl/riscv_insn_decode_stage.sv
// Pipelined LANES-wide RISC-V base decoder stage between fetch and issue.
// One register slice with valid/ready handshake, full throughput and a
// synchronous flush of the held beat.
// Optional: define RISCV_DECODE_PERF_EN to add instruction / illegal
// instruction counters (perf_insn_cnt, perf_illegal_cnt).
module riscv_insn_decode_stage
  import riscv_decode_pkg::*;
#(
  parameter int LANES = 2,
  parameter int XLEN  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES-1:0]             in_lane_vld,
  input  logic [LANES-1:0][31:0]       in_insn,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES-1:0]             out_lane_vld,
  output dec_info_t [LANES-1:0]        out_info
`ifdef RISCV_DECODE_PERF_EN
  ,
  output logic [31:0]                  perf_insn_cnt,
  output logic [31:0]                  perf_illegal_cnt
`endif
);

  dec_info_t [LANES-1:0] dec;
  logic                  xfer;

  // One combinational decoder per lane.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    riscv_insn_decode_lane #(.XLEN(XLEN)) u_lane (
      .insn (in_insn[l]),
      .info (dec[l])
    );
  end

  // Slot is free when empty or being drained this cycle; flush does not gate it.
  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;

  // Output slice: flush wins over a same-cycle transfer, which is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_lane_vld <= '0;
      out_info     <= '0;
    end else if (flush) begin
      out_valid    <= 1'b0;
    end else if (xfer) begin
      out_valid    <= 1'b1;
      out_lane_vld <= in_lane_vld;
      out_info     <= dec;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

`ifdef RISCV_DECODE_PERF_EN
  logic [31:0] insn_inc;
  logic [31:0] ill_inc;

  // Population counts of present lanes and present-and-illegal lanes.
  always_comb begin
    insn_inc = 32'd0;
    ill_inc  = 32'd0;
    for (int l = 0; l < LANES; l++) begin
      insn_inc = insn_inc + 32'(in_lane_vld[l]);
      ill_inc  = ill_inc  + 32'(in_lane_vld[l] & dec[l].illegal);
    end
  end

  // Counters advance only on beats that actually land; they wrap at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_insn_cnt    <= 32'd0;
      perf_illegal_cnt <= 32'd0;
    end else if (xfer && !flush) begin
      perf_insn_cnt    <= perf_insn_cnt + insn_inc;
      perf_illegal_cnt <= perf_illegal_cnt + ill_inc;
    end
  end
`endif

endmodule
